// File: rtl/t03_seq_alu_if.sv
// Operand/result handshake bundle for the sequential ALU.
// The master drives operands and flush; the slave returns ready, the result and flags.
interface t03_seq_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       fop;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             Z;
   logic             N;
   logic             V;

   modport master (
      output flush, in_valid, fop, a, b,
      input  in_ready, out_valid, result, Z, N, V
   );

   modport slave (
      input  flush, in_valid, fop, a, b,
      output in_ready, out_valid, result, Z, N, V
   );
endinterface

// File: rtl/t03_seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative RV32M-style mul/div.
// Results and flags are registered and announced by a one-cycle out_valid pulse.
module t03_seq_alu #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk,
   input logic          nRst,
   t03_seq_alu_if.slave bus
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [3:0]         op_q;
   logic [WIDTH:0]     hi_q;    // mul: product high half; div: partial remainder
   logic [WIDTH-1:0]   lo_q;    // mul: multiplier/product low; div: dividend/quotient
   logic [WIDTH-1:0]   opnd_q;  // multiplicand or divisor magnitude
   logic               neg_q_q;
   logic               neg_r_q;
   logic [WIDTH-1:0]   result_q;
   logic               z_q, n_q, v_q, out_valid_q;

   logic               a_s, b_s;
   logic [WIDTH-1:0]   alu_res, mag_a, mag_b;
   logic               alu_v;
   logic signed [WIDTH-1:0] a_sg;
   logic [SHW-1:0]     sh;
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   fix_res;

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.Z         = z_q;
   assign bus.N         = n_q;
   assign bus.V         = v_q;

   always_comb begin
      a_s     = bus.a[WIDTH-1];
      b_s     = bus.b[WIDTH-1];
      a_sg    = bus.a;
      sh      = bus.b[SHW-1:0];
      mag_a   = a_s ? -bus.a : bus.a;
      mag_b   = b_s ? -bus.b : bus.b;
      alu_res = '0;
      alu_v   = 1'b0;
      case (bus.fop)
         4'd0: begin
            alu_res = bus.a + bus.b;
            alu_v   = (a_s == b_s) && (alu_res[WIDTH-1] != a_s);
         end
         4'd1: begin
            alu_res = bus.a - bus.b;
            alu_v   = (a_s != b_s) && (alu_res[WIDTH-1] != a_s);
         end
         4'd2:    alu_res = bus.a << sh;
         4'd3:    alu_res = bus.a >> sh;
         4'd4:    alu_res = a_sg >>> sh;
         4'd5:    alu_res = bus.a & bus.b;
         4'd6:    alu_res = bus.a | bus.b;
         4'd7:    alu_res = bus.a ^ bus.b;
         4'd8:    alu_res = bus.b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      mul_sum  = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
      div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
      prod_s   = neg_q_q ? -{hi_q[WIDTH-1:0], lo_q} : {hi_q[WIDTH-1:0], lo_q};
      case (op_q)
         4'd9:         fix_res = prod_s[WIDTH-1:0];
         4'd10, 4'd11: fix_res = prod_s[2*WIDTH-1:WIDTH];
         4'd12, 4'd13: fix_res = neg_q_q ? -lo_q : lo_q;
         default:      fix_res = neg_r_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         op_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         result_q    <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (bus.flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.in_valid) begin
                     op_q <= bus.fop;
                     if (bus.fop <= 4'd8) begin
                        result_q    <= alu_res;
                        z_q         <= (alu_res == '0);
                        n_q         <= alu_res[WIDTH-1];
                        v_q         <= alu_v;
                        out_valid_q <= 1'b1;
                     end else if (bus.fop <= 4'd11) begin
                        state_q <= StMul;
                        cnt_q   <= CW'(WIDTH);
                        hi_q    <= '0;
                        lo_q    <= (bus.fop == 4'd10) ? mag_a : bus.a;
                        opnd_q  <= (bus.fop == 4'd10) ? mag_b : bus.b;
                        neg_q_q <= (bus.fop == 4'd10) && (a_s ^ b_s);
                        neg_r_q <= 1'b0;
                     end else if (bus.b == '0) begin
                        // Divide by zero: quotient all ones, remainder = dividend.
                        state_q <= StFix;
                        cnt_q   <= '0;
                        hi_q    <= {1'b0, bus.a};
                        lo_q    <= '1;
                        neg_q_q <= 1'b0;
                        neg_r_q <= 1'b0;
                     end else begin
                        state_q <= StDiv;
                        cnt_q   <= CW'(WIDTH);
                        hi_q    <= '0;
                        lo_q    <= !bus.fop[0] ? mag_a : bus.a;
                        opnd_q  <= !bus.fop[0] ? mag_b : bus.b;
                        neg_q_q <= !bus.fop[0] && (a_s ^ b_s);
                        neg_r_q <= !bus.fop[0] && a_s;
                     end
                  end
               end
               StMul: begin
                  hi_q  <= {1'b0, mul_sum[WIDTH:1]};
                  lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CW'(1)) state_q <= StFix;
               end
               StDiv: begin
                  hi_q  <= div_diff[WIDTH+1] ? rem_sh : div_diff[WIDTH:0];
                  lo_q  <= {lo_q[WIDTH-2:0], !div_diff[WIDTH+1]};
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CW'(1)) state_q <= StFix;
               end
               StFix: begin
                  result_q    <= fix_res;
                  z_q         <= (fix_res == '0);
                  n_q         <= fix_res[WIDTH-1];
                  v_q         <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StIdle;
               end
            endcase
         end
      end
   end
endmodule
